// File: rtl/mips_dump_pkg.sv
// Shared types and constants for the MIPS debug state-dump unit.
package mips_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REGS   = 2'd1,
    ST_IMEM   = 2'd2,
    ST_FOOTER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TAG_REG    = 2'b00,
    TAG_IMEM   = 2'b01,
    TAG_FOOTER = 2'b10
  } tag_t;

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;
  localparam int          IDX_W    = 16;

endpackage

// File: rtl/mips_dump_outreg.sv
// Output holding register for the dump stream: loads a new word on request,
// otherwise holds, so the sink sees stable data while it applies backpressure.
module mips_dump_outreg
  import mips_dump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  tag_t              ld_tag,
  input  logic [IDX_W-1:0]  ld_index,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output tag_t              out_tag,
  output logic [IDX_W-1:0]  out_index
);

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  tag_t              tag_p1;
  logic [IDX_W-1:0]  idx_p1;

  // Stage p1: presented word; data is cleared on reset too, since every
  // output must read zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= TAG_REG;
      idx_p1  <= '0;
    end else if (ld) begin
      vld_p1  <= ld_valid;
      data_p1 <= ld_data;
      tag_p1  <= ld_tag;
      idx_p1  <= ld_index;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_tag   = tag_p1;
  assign out_index = idx_p1;

endmodule

// File: rtl/mips_state_dump.sv
// Debug readback: streams the register file, then instruction memory, then a
// count/XOR footer. Optional macro DUMP_SENTINEL_STOP_EN ends IMEM at 32'hFFFF_FFFF.
module mips_state_dump
  import mips_dump_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_REGS)-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]             rf_rdata,
  output logic [$clog2(IMEM_DEPTH)-1:0] im_raddr,
  input  logic [DATA_W-1:0]             im_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [1:0]                    out_tag,
  output logic [IDX_W-1:0]              out_index
);

  localparam int RA_W = $clog2(NUM_REGS);
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_IM  = IDX_W'(IMEM_DEPTH - 1);

  state_t            state, state_nxt;
  logic [RA_W-1:0]   rf_nxt;
  logic [IA_W-1:0]   im_nxt;
  logic [DATA_W-1:0] csum, csum_nxt, csum_upd;
  logic [IDX_W-1:0]  cnt, cnt_nxt, cnt_upd;
  logic [IDX_W-1:0]  idx_inc;
  logic              done_nxt;
  logic              xfer;
  logic              im_stop;

  logic              ld;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  tag_t              ld_tag;
  logic [IDX_W-1:0]  ld_index;
  tag_t              tag_q;

`ifdef DUMP_SENTINEL_STOP_EN
  assign im_stop = (im_rdata == DATA_W'(SENTINEL));
`else
  assign im_stop = 1'b0;
`endif

  assign xfer     = out_valid & out_ready;
  // Footer must include the data word being accepted this cycle.
  assign csum_upd = csum ^ out_data;
  assign cnt_upd  = cnt + IDX_W'(1);
  assign idx_inc  = out_index + IDX_W'(1);
  assign busy     = (state != ST_IDLE);
  assign out_tag  = tag_q;

  always_comb begin
    state_nxt = state;
    rf_nxt    = rf_raddr;
    im_nxt    = im_raddr;
    csum_nxt  = csum;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ld        = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_tag    = TAG_REG;
    ld_index  = '0;

    if (xfer && (state == ST_REGS || state == ST_IMEM)) begin
      csum_nxt = csum_upd;
      cnt_nxt  = cnt_upd;
    end

    case (state)
      ST_IDLE: begin
        if (start) begin
          ld        = 1'b1;
          ld_valid  = 1'b1;
          ld_data   = rf_rdata;
          ld_tag    = TAG_REG;
          ld_index  = '0;
          rf_nxt    = RA_W'(1);
          csum_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = ST_REGS;
        end
      end

      ST_REGS: begin
        if (xfer) begin
          ld       = 1'b1;
          ld_valid = 1'b1;
          if (out_index == LAST_REG) begin
            rf_nxt = '0;
            if (im_stop) begin
              ld_data   = csum_upd;
              ld_tag    = TAG_FOOTER;
              ld_index  = cnt_upd;
              im_nxt    = '0;
              state_nxt = ST_FOOTER;
            end else begin
              ld_data   = im_rdata;
              ld_tag    = TAG_IMEM;
              ld_index  = '0;
              im_nxt    = IA_W'(1);
              state_nxt = ST_IMEM;
            end
          end else begin
            ld_data  = rf_rdata;
            ld_tag   = TAG_REG;
            ld_index = idx_inc;
            rf_nxt   = (idx_inc == LAST_REG) ? '0 : rf_raddr + RA_W'(1);
          end
        end
      end

      ST_IMEM: begin
        if (xfer) begin
          ld       = 1'b1;
          ld_valid = 1'b1;
          if (out_index == LAST_IM || im_stop) begin
            ld_data   = csum_upd;
            ld_tag    = TAG_FOOTER;
            ld_index  = cnt_upd;
            im_nxt    = '0;
            state_nxt = ST_FOOTER;
          end else begin
            ld_data  = im_rdata;
            ld_tag   = TAG_IMEM;
            ld_index = idx_inc;
            im_nxt   = (idx_inc == LAST_IM) ? '0 : im_raddr + IA_W'(1);
          end
        end
      end

      ST_FOOTER: begin
        // Footer accepted: clear the output register back to its idle value.
        if (xfer) begin
          ld        = 1'b1;
          ld_valid  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: control state, read addresses, running checksum and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rf_raddr <= '0;
      im_raddr <= '0;
      csum     <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rf_raddr <= rf_nxt;
      im_raddr <= im_nxt;
      csum     <= csum_nxt;
      cnt      <= cnt_nxt;
      done     <= done_nxt;
    end
  end

  mips_dump_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_tag    (ld_tag),
    .ld_index  (ld_index),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (tag_q),
    .out_index (out_index)
  );

endmodule

// File: tb/tb_mips_state_dump.sv
// Bench for mips_state_dump: fixed scenario table, hand sequences for stall
// and mid-dump reset, then randomized memories checked against a stream model.
module tb_mips_state_dump;

  localparam int NR = 8;
  localparam int ID = 16;
`ifdef DUMP_SENTINEL_STOP_EN
  localparam bit SENT_ON = 1'b1;
  localparam logic [15:0] EXP_CNT = 16'd15;
`else
  localparam bit SENT_ON = 1'b0;
  localparam logic [15:0] EXP_CNT = 16'd24;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, out_valid;
  logic [2:0]  rf_raddr;
  logic [3:0]  im_raddr;
  logic [31:0] rf_rdata, im_rdata, out_data;
  logic [1:0]  out_tag;
  logic [15:0] out_index;

  logic [31:0] regs [NR];
  logic [31:0] imem [ID];

  assign rf_rdata = regs[rf_raddr];
  assign im_rdata = imem[im_raddr];

  always #5 clk = ~clk;

  mips_state_dump #(.NUM_REGS(NR), .IMEM_DEPTH(ID), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .im_raddr  (im_raddr),
    .im_rdata  (im_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_index (out_index)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  tag;
    logic [15:0] idx;
  } word_t;

  typedef struct {
    int          mode;
    int          start_again;
    logic [15:0] exp_cnt;
    logic [31:0] exp_csum;
  } vec_t;

  word_t exp_q[$];
  vec_t  tbl [4];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_done"}, 64'(done), 64'(0));
    chk({name, "_valid"}, 64'(out_valid), 64'(0));
    chk({name, "_data"}, 64'(out_data), 64'(0));
    chk({name, "_tag"}, 64'(out_tag), 64'(0));
    chk({name, "_index"}, 64'(out_index), 64'(0));
    chk({name, "_rfaddr"}, 64'(rf_raddr), 64'(0));
    chk({name, "_imaddr"}, 64'(im_raddr), 64'(0));
  endtask

  // Expected stream: every register, imem words up to (optional) sentinel, footer.
  task automatic build_expected();
    logic [31:0] x;
    int          n;
    x = '0;
    n = 0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back('{regs[i], 2'b00, 16'(i)});
      x ^= regs[i];
      n++;
    end
    for (int j = 0; j < ID; j++) begin
      if (SENT_ON && imem[j] == 32'hFFFF_FFFF) break;
      exp_q.push_back('{imem[j], 2'b01, 16'(j)});
      x ^= imem[j];
      n++;
    end
    exp_q.push_back('{x, 2'b10, 16'(n)});
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic load_setup();
    logic [31:0] r [6];
    r = '{32'd2, 32'd4, 32'd6, 32'd3, 32'd1, 32'd8};
    for (int i = 0; i < NR; i++) regs[i] = (i < 6) ? r[i] : 32'd0;
    for (int j = 0; j < ID; j++)
      imem[j] = (j <= 6) ? 32'h0082_1020 : (j <= 10) ? 32'hFFFF_FFFF : 32'd0;
  endtask

  task automatic run_dump(input int mode, input int start_again,
                          output logic [31:0] fdata, output logic [15:0] fidx);
    int          k, cyc, footer_cyc, sa;
    bit          fin, stall;
    logic [57:0] prev, cur;
    build_expected();
    sa = (start_again < 0) ? exp_q.size() - 1 : start_again;
    k = 0; cyc = 0; footer_cyc = -1; fin = 1'b0; stall = 1'b0;
    prev = '0; fdata = '0; fidx = '0;
    @(negedge clk);
    start = 1'b1;
    out_ready = rdy(mode, 0);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_valid", 64'(out_valid), 64'(1));
    while (!fin && cyc < 3000) begin
      cur = {out_valid, out_data, out_tag, out_index, rf_raddr, im_raddr};
      if (stall) chk("stall_hold", 64'(cur), 64'(prev));
      if (footer_cyc >= 0) begin
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_valid", 64'(out_valid), 64'(0));
        fin = 1'b1;
      end else begin
        chk("done_early", 64'(done), 64'(0));
        out_ready = rdy(mode, cyc);
        start = (k == sa);
        stall = out_valid && !out_ready;
        prev = cur;
        if (out_valid && out_ready) begin
          if (k < exp_q.size()) begin
            chk("word_data", 64'(out_data), 64'(exp_q[k].data));
            chk("word_tag", 64'(out_tag), 64'(exp_q[k].tag));
            chk("word_index", 64'(out_index), 64'(exp_q[k].idx));
            if (exp_q[k].tag == 2'b10) begin
              footer_cyc = cyc;
              fdata = out_data;
              fidx = out_index;
            end
          end else begin
            chk("extra_word", 64'(k), 64'(exp_q.size()));
          end
          k++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("dump_timeout", 64'(fin), 64'(1));
    chk("word_count", 64'(k), 64'(exp_q.size()));
    if (mode == 0) chk("no_bubbles", 64'(footer_cyc), 64'(exp_q.size() - 1));
    @(negedge clk);
    chk("after_done_busy", 64'(busy), 64'(0));
    chk("after_done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    logic [31:0] fdata;
    logic [15:0] fidx;
    int          w;

    load_setup();
    tbl[0] = '{0, 9999, EXP_CNT, 32'h0082_102A};
    tbl[1] = '{1, 9999, EXP_CNT, 32'h0082_102A};
    tbl[2] = '{0, 3,    EXP_CNT, 32'h0082_102A};
    tbl[3] = '{0, -1,   EXP_CNT, 32'h0082_102A};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_zero("idle");

    for (int t = 0; t < 4; t++) begin
      run_dump(tbl[t].mode, tbl[t].start_again, fdata, fidx);
      chk($sformatf("tbl%0d_footer_data", t), 64'(fdata), 64'(tbl[t].exp_csum));
      chk($sformatf("tbl%0d_footer_cnt", t), 64'(fidx), 64'(tbl[t].exp_cnt));
    end

    // Start under backpressure: reg[0] held, read address parked at 1.
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_data", 64'(out_data), 64'(2));
      chk("bp_rfaddr", 64'(rf_raddr), 64'(1));
      @(negedge clk);
    end

    // Reset while imem word 2 is presented abandons the dump.
    out_ready = 1'b1;
    w = 0;
    while (!(out_valid && out_tag == 2'b01 && out_index == 16'd2) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("reach_imem2", 64'(w < 200), 64'(1));
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    rst = 1'b1;
    @(negedge clk);
    run_dump(0, 9999, fdata, fidx);
    chk("restart_footer_data", 64'(fdata), 64'(32'h0082_102A));
    chk("restart_footer_cnt", 64'(fidx), 64'(EXP_CNT));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      for (int j = 0; j < ID; j++)
        imem[j] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
      run_dump(2, 9999, fdata, fidx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
